// File: rtl/game_pkg.sv
// Shared encodings, the LFSR seed and small BCD helpers for the round sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_PLAY      = 3'd2,
        ST_CHECK     = 3'd3,
        ST_ROUND_WIN = 3'd4,
        ST_GAME_WIN  = 3'd5,
        ST_GAME_OVER = 3'd6
    } state_t;

    localparam logic [1:0] HINT_NONE  = 2'b00;
    localparam logic [1:0] HINT_LOW   = 2'b01;
    localparam logic [1:0] HINT_HIGH  = 2'b10;
    localparam logic [1:0] HINT_EQUAL = 2'b11;

    localparam logic [1:0] WL_NONE = 2'b00;
    localparam logic [1:0] WL_WIN  = 2'b01;
    localparam logic [1:0] WL_LOSE = 2'b10;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [3:0] mod10(input logic [3:0] n);
        return (n > 4'd9) ? n - 4'd10 : n;
    endfunction

    // Digits beyond the number in play contribute nothing to the value.
    function automatic logic [9:0] bcd_value(input logic [3:0] d3, input logic [3:0] d2,
                                             input logic [3:0] d1, input logic [1:0] ndig);
        logic [9:0] v;
        v = {6'd0, d1};
        if (ndig >= 2'd2) v = v + 10'(d2) * 10'd10;
        if (ndig >= 2'd3) v = v + 10'(d3) * 10'd100;
        return v;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); exposes the low three nibbles.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [11:0] nib_o
);

    logic [15:0] lfsr_q;
    logic        fb;

    assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= {lfsr_q[14:0], fb};
    end

    assign nib_o = lfsr_q[11:0];

endmodule

// File: rtl/round_sequencer.sv
// Game round sequencer: loads LFSR secrets, times each round, scores BCD guesses
// and tracks round/game win or loss. All outputs are registered.
module round_sequencer
    import game_pkg::*;
#(
    parameter int MAX_WRONG  = 5,
    parameter int ROUND_TIME = 60,
    parameter int NUM_ROUNDS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       confirm,
    input  logic       tick_1hz,
    input  logic [3:0] guess1,
    input  logic [3:0] guess2,
    input  logic [3:0] guess3,
    output logic [3:0] secret1,
    output logic [3:0] secret2,
    output logic [3:0] secret3,
    output logic [1:0] round,
    output logic [1:0] max_digits,
    output logic [2:0] guesses_left,
    output logic [6:0] time_left,
    output logic [1:0] hint,
    output logic [1:0] win_lose,
    output logic [2:0] state
);

    localparam logic [2:0] GL_INIT    = 3'(MAX_WRONG);
    localparam logic [6:0] TIME_INIT  = 7'(ROUND_TIME);
    localparam logic [1:0] ROUND_LAST = 2'(NUM_ROUNDS);

    state_t      state_q;
    logic [1:0]  round_q;
    logic [3:0]  sec1_q, sec2_q, sec3_q;
    logic [2:0]  gleft_q;
    logic [6:0]  tleft_q;
    logic [1:0]  hint_q, wl_q;
    logic [9:0]  guess_q;
    logic [11:0] nib;

    logic        load_go_d;
    logic [1:0]  load_round_d;
    logic        guess_ok_d;
    logic [9:0]  guess_val_d;
    logic [9:0]  secret_val_d;

    lfsr16 u_lfsr (
        .clk_i  (clk),
        .rst_ni (rst),
        .nib_o  (nib)
    );

    // start restarts from anywhere but LOAD and outranks confirm.
    always_comb begin
        load_go_d    = 1'b0;
        load_round_d = 2'd1;
        if (start && state_q != ST_LOAD) begin
            load_go_d = 1'b1;
        end else if (confirm && state_q == ST_ROUND_WIN) begin
            load_go_d    = 1'b1;
            load_round_d = round_q + 2'd1;
        end
    end

    assign guess_ok_d   = (guess1 <= 4'd9) && (round_q < 2'd2 || guess2 <= 4'd9)
                       && (round_q < 2'd3 || guess3 <= 4'd9);
    assign guess_val_d  = bcd_value(guess3, guess2, guess1, round_q);
    assign secret_val_d = bcd_value(sec3_q, sec2_q, sec1_q, round_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            round_q <= 2'd1;
            sec1_q  <= 4'd0;
            sec2_q  <= 4'd0;
            sec3_q  <= 4'd0;
            gleft_q <= GL_INIT;
            tleft_q <= TIME_INIT;
            hint_q  <= HINT_NONE;
            wl_q    <= WL_NONE;
            guess_q <= 10'd0;
        end else if (load_go_d) begin
            state_q <= ST_LOAD;
            round_q <= load_round_d;
            sec1_q  <= mod10(nib[3:0]);
            sec2_q  <= (load_round_d >= 2'd2) ? mod10(nib[7:4])  : 4'd0;
            sec3_q  <= (load_round_d >= 2'd3) ? mod10(nib[11:8]) : 4'd0;
            gleft_q <= GL_INIT;
            tleft_q <= TIME_INIT;
            hint_q  <= HINT_NONE;
            wl_q    <= WL_NONE;
        end else begin
            unique case (state_q)
                ST_LOAD: state_q <= ST_PLAY;
                ST_PLAY: begin
                    // A confirm with an out-of-range digit is treated as absent.
                    if (confirm && guess_ok_d) begin
                        guess_q <= guess_val_d;
                        state_q <= ST_CHECK;
                    end else if (tick_1hz) begin
                        if (tleft_q != 7'd0) tleft_q <= tleft_q - 7'd1;
                        if (tleft_q == 7'd1) begin
                            state_q <= ST_GAME_OVER;
                            wl_q    <= WL_LOSE;
                        end
                    end
                end
                ST_CHECK: begin
                    if (guess_q == secret_val_d) begin
                        hint_q <= HINT_EQUAL;
                        if (round_q == ROUND_LAST) begin
                            state_q <= ST_GAME_WIN;
                            wl_q    <= WL_WIN;
                        end else begin
                            state_q <= ST_ROUND_WIN;
                        end
                    end else begin
                        hint_q <= (guess_q < secret_val_d) ? HINT_LOW : HINT_HIGH;
                        if (gleft_q != 3'd0) gleft_q <= gleft_q - 3'd1;
                        if (gleft_q <= 3'd1) begin
                            state_q <= ST_GAME_OVER;
                            wl_q    <= WL_LOSE;
                        end else begin
                            state_q <= ST_PLAY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign secret1      = sec1_q;
    assign secret2      = sec2_q;
    assign secret3      = sec3_q;
    assign round        = round_q;
    assign max_digits   = round_q;
    assign guesses_left = gleft_q;
    assign time_left    = tleft_q;
    assign hint         = hint_q;
    assign win_lose     = wl_q;
    assign state        = state_q;

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- MAX_WRONG, 5, wrong guesses allowed per round (1..7).
- ROUND_TIME, 60, seconds per round (1..99).
- NUM_ROUNDS, 3, rounds per game (1..3).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-low reset.
- start, in, 1, synchronized one-cycle pulse that starts or restarts a game.
- confirm, in, 1, synchronized one-cycle pulse that submits the current guess.
- tick_1hz, in, 1, one-cycle pulse per second.
- guess1/guess2/guess3, in, 4 each, BCD ones/tens/hundreds of the displayed guess.
- secret1/secret2/secret3, out, 4 each, BCD secret digits.
- round, out, 2, current round, 1..NUM_ROUNDS.
- max_digits, out, 2, digits in play (equals round).
- guesses_left, out, 3, remaining wrong guesses.
- time_left, out, 7, seconds remaining.
- hint, out, 2, 00 none, 01 LOW, 10 HIGH, 11 EQUAL.
- win_lose, out, 2, 00 idle/playing, 01 win, 10 lose.
- state, out, 3, FSM state for the LEDs.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, PLAY, CHECK, ROUND_WIN, GAME_WIN and GAME_OVER.

REQ-004 Transitions SHALL be as follows.
- IDLE: start -> LOAD with round=1.
- LOAD: one cycle, then PLAY.
- PLAY: confirm -> CHECK; otherwise tick_1hz with time_left==1 -> GAME_OVER.
- CHECK: one cycle, then ROUND_WIN, PLAY or GAME_OVER.
- ROUND_WIN: confirm -> LOAD with round+1.
- GAME_WIN and GAME_OVER: start -> LOAD with round=1.

REQ-005 In LOAD, secretN SHALL be the corresponding LFSR nibble (bits [3:0], [7:4], [11:8]) reduced mod 10; digits above max_digits SHALL be forced to 0.

REQ-006 LOAD SHALL set time_left=ROUND_TIME, guesses_left=MAX_WRONG and hint=00.

REQ-007 The guess value SHALL be guess3*100+guess2*10+guess1, with digits above max_digits treated as 0; comparison SHALL be unsigned against the secret value formed the same way.

REQ-008 In CHECK, hint SHALL be set to LOW, HIGH or EQUAL, and hint SHALL hold until the next CHECK or LOAD.

REQ-009 CHECK with EQUAL SHALL go to ROUND_WIN; if round==NUM_ROUNDS it SHALL go to GAME_WIN instead.

REQ-010 CHECK with no match SHALL decrement guesses_left; on reaching 0 it SHALL go to GAME_OVER, otherwise to PLAY.

REQ-011 A confirm in PLAY SHALL be ignored (no CHECK, no guess consumed) when any in-use guess digit is greater than 9.

REQ-012 time_left SHALL decrement on tick_1hz only in PLAY, SHALL saturate at 0 and SHALL freeze in every other state.

REQ-013 When confirm and tick_1hz coincide in PLAY, confirm SHALL win and the tick SHALL be dropped.

REQ-014 win_lose SHALL be 01 in GAME_WIN, 10 in GAME_OVER and 00 in all other states.

REQ-015 start SHALL restart the game from LOAD in any state except IDLE and LOAD; in PLAY, start SHALL take priority over confirm.

REQ-016 All outputs SHALL be registered and change on the clock edge after the causing input, i.e. one cycle of latency.

Reset
REQ-017 While rst==0 at a clk edge, the block SHALL enter IDLE with round=1, max_digits=1, guesses_left=MAX_WRONG, time_left=ROUND_TIME, hint=00, win_lose=00, secrets=0 and LFSR=16'hACE1.

REQ-018 A reset mid-game SHALL take effect in one cycle; all input pulses seen during reset SHALL be ignored.

Structure
REQ-019 The state enum, the hint and win_lose encodings and the LFSR seed SHALL live in the shared package game_pkg.

REQ-020 The LFSR SHALL be a sub-module lfsr16 with these properties:
- Fibonacci form, taps 16,14,13,11.
- Free-running, advancing every cycle.
- Synchronous active-low reset to the seed.

REQ-021 The target implementation size SHALL be 150-300 lines of RTL.

Verification
REQ-022 Reset then start -> LOAD for one cycle, then PLAY with round=1, secret2=secret3=0, time_left=60 and guesses_left=5.

REQ-023 Round 1 with secret1=7: guess 3 -> hint=01 and guesses_left=4; guess 9 -> hint=10; guess 7 -> ROUND_WIN; confirm -> round=2.

REQ-024 Five wrong guesses -> GAME_OVER with win_lose=10; a following start -> PLAY with round=1.

REQ-025 Sixty ticks with no confirm -> time_left reaches 0 and GAME_OVER; a tick coinciding with confirm at time_left=1 -> CHECK, with time_left still 1.

REQ-026 Round 2 with guess2=4'hA -> confirm ignored, guesses_left unchanged; winning round 3 -> GAME_WIN with win_lose=01.

REQ-027 rst=0 asserted for one cycle during CHECK -> IDLE and all outputs at their reset values on the next cycle.
